player_state_rx: RTL and testbench

//  Receives remote-player state packets from the inter-FPGA serial link as a byte stream and unpacks them.

---
 rtl/overcooked_pkg.sv | 54 +++++
 rtl/player_pkt_parser.sv | 95 +++++++++
 rtl/player_state_rx.sv | 142 ++++++++++++++
 tb/tb_player_state_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overcooked_pkg.sv
// Shared types and constants for the inter-FPGA player-state link.
package overcooked_pkg;

    typedef enum logic [2:0] {
        WELCOME = 3'd0,
        START   = 3'd1,
        PLAY    = 3'd2,
        PAUSE   = 3'd3,
        FINISH  = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam logic [7:0] PKT_SYNC = 8'hA5;
    localparam int         PKT_LEN  = 5;

    // Each state names the byte that the next rx_valid will deliver.
    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        GOT_B1 = 3'd1,
        GOT_B2 = 3'd2,
        GOT_B3 = 3'd3,
        CHECK  = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        dir_t       dir;
        logic       chop;
        logic       carry;
    } player_state_t;

    function automatic player_state_t parked_state(input logic [8:0] px, input logic [8:0] py);
        player_state_t s;
        s.x     = px;
        s.y     = py;
        s.dir   = DOWN;
        s.chop  = 1'b0;
        s.carry = 1'b0;
        return s;
    endfunction

    // Remote IDs are packed into slots a,b,c skipping the local board's own ID.
    function automatic logic [1:0] slot_of(input logic [1:0] id, input logic [1:0] local_id);
        return (id < local_id) ? id : id - 2'd1;
    endfunction

endpackage

// File: rtl/player_pkt_parser.sv
// Byte-stream packet parser: sync hunt, inter-byte gap abort, checksum and ID validation.
module player_pkt_parser
    import overcooked_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE       = PKT_SYNC,
    parameter logic [15:0] BYTE_GAP_CYCLES = 16'd50000
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic [1:0]    num_players,
    input  logic [1:0]    local_player_ID,
    output logic          pkt_good,
    output logic          pkt_bad,
    output player_state_t pkt_state,
    output logic [1:0]    pkt_id
);

    rx_state_t   state, state_next;
    logic [7:0]  b1, b2, b3;
    logic [15:0] gap_cnt;
    logic        gap_expire;
    logic        csum_ok;
    logic        id_ok;

    assign pkt_id          = b1[1:0];
    assign pkt_state.x     = {b1[7], b2};
    assign pkt_state.y     = {b1[6], b3};
    assign pkt_state.chop  = b1[5];
    assign pkt_state.carry = b1[4];
    assign pkt_state.dir   = dir_t'(b1[3:2]);

    assign csum_ok    = (rx_data == (b1 ^ b2 ^ b3));
    assign id_ok      = (pkt_id != local_player_ID) && (pkt_id <= num_players);
    assign gap_expire = (state != HUNT) && !rx_valid && (gap_cnt == BYTE_GAP_CYCLES - 16'd1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // A byte arriving in the expiry cycle takes priority over the gap abort.
    always_comb begin
        state_next = state;
        pkt_good   = 1'b0;
        pkt_bad    = 1'b0;
        if (rx_valid) begin
            case (state)
                HUNT:    if (rx_data == SYNC_BYTE) state_next = GOT_B1;
                GOT_B1:  state_next = GOT_B2;
                GOT_B2:  state_next = GOT_B3;
                GOT_B3:  state_next = CHECK;
                CHECK: begin
                    state_next = HUNT;
                    if (csum_ok && id_ok) pkt_good = 1'b1;
                    else                  pkt_bad  = 1'b1;
                end
                default: state_next = HUNT;
            endcase
        end else if (gap_expire) begin
            state_next = HUNT;
            pkt_bad    = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            b1 <= 8'h00;
            b2 <= 8'h00;
            b3 <= 8'h00;
        end else if (rx_valid) begin
            case (state)
                GOT_B1:  b1 <= rx_data;
                GOT_B2:  b2 <= rx_data;
                GOT_B3:  b3 <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= 16'd0;
        end else if (rx_valid || state == HUNT || gap_expire) begin
            gap_cnt <= 16'd0;
        end else begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/player_state_rx.sv
// Receive end of the player-state link: maps parsed packets onto remote slots a/b/c,
// ages out silent slots and keeps link statistics.
module player_state_rx
    import overcooked_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE       = PKT_SYNC,
    parameter logic [15:0] BYTE_GAP_CYCLES = 16'd50000,
    parameter logic [26:0] TIMEOUT_CYCLES  = 27'd65000000,
    parameter logic [8:0]  PARK_X          = 9'd0,
    parameter logic [8:0]  PARK_Y          = 9'd0
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [2:0]  game_state,
    input  logic [1:0]  num_players,
    input  logic [1:0]  local_player_ID,
    output logic [8:0]  player_a_x,
    output logic [8:0]  player_a_y,
    output logic [1:0]  player_a_dir,
    output logic        player_a_chop,
    output logic        player_a_carry,
    output logic [8:0]  player_b_x,
    output logic [8:0]  player_b_y,
    output logic [1:0]  player_b_dir,
    output logic        player_b_chop,
    output logic        player_b_carry,
    output logic [8:0]  player_c_x,
    output logic [8:0]  player_c_y,
    output logic [1:0]  player_c_dir,
    output logic        player_c_chop,
    output logic        player_c_carry,
    output logic [2:0]  slot_valid,
    output logic [15:0] pkt_ok_count,
    output logic [7:0]  pkt_err_count
);

    logic          pkt_good;
    logic          pkt_bad;
    player_state_t pkt_state;
    logic [1:0]    pkt_id;
    logic [1:0]    commit_slot;

    player_state_t slot_q [3];
    logic [26:0]   tmo_cnt [3];
    logic [2:0]    valid_q;
    logic [1:0]    num_players_q;
    logic [1:0]    local_id_q;
    logic          cfg_change;
    logic [2:0]    park_req;
    logic [2:0]    commit_req;
    logic [2:0]    expire_req;

    player_pkt_parser #(
        .SYNC_BYTE       (SYNC_BYTE),
        .BYTE_GAP_CYCLES (BYTE_GAP_CYCLES)
    ) u_parser (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .num_players     (num_players),
        .local_player_ID (local_player_ID),
        .pkt_good        (pkt_good),
        .pkt_bad         (pkt_bad),
        .pkt_state       (pkt_state),
        .pkt_id          (pkt_id)
    );

    assign commit_slot = slot_of(pkt_id, local_player_ID);
    assign cfg_change  = (num_players != num_players_q) || (local_player_ID != local_id_q);

    // Forced parking outranks a commit, which in turn outranks timeout expiry.
    always_comb begin
        park_req   = 3'b000;
        commit_req = 3'b000;
        expire_req = 3'b000;
        for (int s = 0; s < 3; s++) begin
            park_req[s]   = (game_state_t'(game_state) == WELCOME) || cfg_change ||
                            (s >= int'(num_players));
            commit_req[s] = pkt_good && (commit_slot == 2'(s));
            expire_req[s] = valid_q[s] && (tmo_cnt[s] == TIMEOUT_CYCLES - 27'd1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                slot_q[s]  <= parked_state(PARK_X, PARK_Y);
                tmo_cnt[s] <= 27'd0;
            end
            valid_q <= 3'b000;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (park_req[s] || (expire_req[s] && !commit_req[s])) begin
                    slot_q[s]  <= parked_state(PARK_X, PARK_Y);
                    valid_q[s] <= 1'b0;
                    tmo_cnt[s] <= 27'd0;
                end else if (commit_req[s]) begin
                    slot_q[s]  <= pkt_state;
                    valid_q[s] <= 1'b1;
                    tmo_cnt[s] <= 27'd0;
                end else if (valid_q[s]) begin
                    tmo_cnt[s] <= tmo_cnt[s] + 27'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pkt_ok_count  <= 16'd0;
            pkt_err_count <= 8'd0;
            num_players_q <= 2'd0;
            local_id_q    <= 2'd0;
        end else begin
            num_players_q <= num_players;
            local_id_q    <= local_player_ID;
            if (pkt_good) pkt_ok_count <= pkt_ok_count + 16'd1;
            if (pkt_bad && pkt_err_count != 8'hFF) pkt_err_count <= pkt_err_count + 8'd1;
        end
    end

    assign player_a_x     = slot_q[0].x;
    assign player_a_y     = slot_q[0].y;
    assign player_a_dir   = slot_q[0].dir;
    assign player_a_chop  = slot_q[0].chop;
    assign player_a_carry = slot_q[0].carry;
    assign player_b_x     = slot_q[1].x;
    assign player_b_y     = slot_q[1].y;
    assign player_b_dir   = slot_q[1].dir;
    assign player_b_chop  = slot_q[1].chop;
    assign player_b_carry = slot_q[1].carry;
    assign player_c_x     = slot_q[2].x;
    assign player_c_y     = slot_q[2].y;
    assign player_c_dir   = slot_q[2].dir;
    assign player_c_chop  = slot_q[2].chop;
    assign player_c_carry = slot_q[2].carry;
    assign slot_valid     = valid_q;

endmodule

// File: tb/tb_player_state_rx.sv
// Directed bench for player_state_rx: vector table of packets plus hand-built gap,
// timeout and reset sequences. Gap and timeout limits are shortened for simulation.
module tb_player_state_rx;

    localparam int GAP = 40;
    localparam int TMO = 400;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  game_state;
    logic [1:0]  num_players;
    logic [1:0]  local_player_ID;
    logic [8:0]  player_a_x, player_a_y, player_b_x, player_b_y, player_c_x, player_c_y;
    logic [1:0]  player_a_dir, player_b_dir, player_c_dir;
    logic        player_a_chop, player_a_carry, player_b_chop, player_b_carry;
    logic        player_c_chop, player_c_carry;
    logic [2:0]  slot_valid;
    logic [15:0] pkt_ok_count;
    logic [7:0]  pkt_err_count;

    int tests_run  = 0;
    int fail_count = 0;
    int exp_ok     = 0;
    int exp_err    = 0;

    logic [8:0] sx [3];
    logic [8:0] sy [3];
    logic [1:0] sd [3];
    logic       sc [3];
    logic       sk [3];

    assign sx[0] = player_a_x;  assign sy[0] = player_a_y;  assign sd[0] = player_a_dir;
    assign sx[1] = player_b_x;  assign sy[1] = player_b_y;  assign sd[1] = player_b_dir;
    assign sx[2] = player_c_x;  assign sy[2] = player_c_y;  assign sd[2] = player_c_dir;
    assign sc[0] = player_a_chop;  assign sk[0] = player_a_carry;
    assign sc[1] = player_b_chop;  assign sk[1] = player_b_carry;
    assign sc[2] = player_c_chop;  assign sk[2] = player_c_carry;

    always #5 clk_in = ~clk_in;

    player_state_rx #(
        .BYTE_GAP_CYCLES (16'(GAP)),
        .TIMEOUT_CYCLES  (27'(TMO))
    ) dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .game_state      (game_state),
        .num_players     (num_players),
        .local_player_ID (local_player_ID),
        .player_a_x      (player_a_x),
        .player_a_y      (player_a_y),
        .player_a_dir    (player_a_dir),
        .player_a_chop   (player_a_chop),
        .player_a_carry  (player_a_carry),
        .player_b_x      (player_b_x),
        .player_b_y      (player_b_y),
        .player_b_dir    (player_b_dir),
        .player_b_chop   (player_b_chop),
        .player_b_carry  (player_b_carry),
        .player_c_x      (player_c_x),
        .player_c_y      (player_c_y),
        .player_c_dir    (player_c_dir),
        .player_c_chop   (player_c_chop),
        .player_c_carry  (player_c_carry),
        .slot_valid      (slot_valid),
        .pkt_ok_count    (pkt_ok_count),
        .pkt_err_count   (pkt_err_count)
    );

    typedef struct {
        logic [1:0] lid;
        logic [1:0] nump;
        logic [2:0] gs;
        logic [1:0] id;
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] dir;
        logic       chop;
        logic       carry;
        logic       bad;
        int         exp_slot;
        logic [2:0] exp_valid;
        int         ok_inc;
        int         err_inc;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic checkSlot(input string tag, input int s, input logic [8:0] x, input logic [8:0] y,
                             input logic [1:0] d, input logic c, input logic k);
        checkOutput({tag, ".x"}, 32'(sx[s]), 32'(x));
        checkOutput({tag, ".y"}, 32'(sy[s]), 32'(y));
        checkOutput({tag, ".dir"}, 32'(sd[s]), 32'(d));
        checkOutput({tag, ".chop"}, 32'(sc[s]), 32'(c));
        checkOutput({tag, ".carry"}, 32'(sk[s]), 32'(k));
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, ".ok_count"}, 32'(pkt_ok_count), 32'(exp_ok));
        checkOutput({tag, ".err_count"}, 32'(pkt_err_count), 32'(exp_err));
    endtask

    // Bytes are presented from 1 ns after a rising edge and captured on the next edge.
    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic logic [7:0] b1Of(input logic [1:0] id, input logic [8:0] x, input logic [8:0] y,
                                        input logic [1:0] d, input logic c, input logic k);
        return {x[8], y[8], c, k, d, id};
    endfunction

    task automatic applyStimulus(input logic [1:0] id, input logic [8:0] x, input logic [8:0] y,
                                 input logic [1:0] d, input logic c, input logic k, input logic bad);
        logic [7:0] b1;
        b1 = b1Of(id, x, y, d, c, k);
        sendByte(8'hA5);
        sendByte(b1);
        sendByte(x[7:0]);
        sendByte(y[7:0]);
        sendByte(b1 ^ x[7:0] ^ y[7:0] ^ {7'd0, bad});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        //           lid   nump  gs    id    x      y      dir   chop  carry bad   slot valid   ok err
        vecs[0]  = '{2'd0, 2'd3, 3'd2, 2'd1, 9'd144, 9'd200, 2'd3, 1'b1, 1'b0, 1'b1, -1, 3'b001, 0, 1};
        vecs[1]  = '{2'd0, 2'd3, 3'd2, 2'd1, 9'd7,   9'd8,   2'd0, 1'b0, 1'b1, 1'b0,  0, 3'b001, 1, 0};
        vecs[2]  = '{2'd0, 2'd3, 3'd2, 2'd2, 9'd300, 9'd10,  2'd0, 1'b0, 1'b1, 1'b0,  1, 3'b011, 1, 0};
        vecs[3]  = '{2'd0, 2'd3, 3'd2, 2'd0, 9'd50,  9'd60,  2'd1, 1'b0, 1'b0, 1'b0, -1, 3'b011, 0, 1};
        vecs[4]  = '{2'd0, 2'd1, 3'd2, 2'd1, 9'd5,   9'd6,   2'd1, 1'b0, 1'b0, 1'b0,  0, 3'b001, 1, 0};
        vecs[5]  = '{2'd0, 2'd1, 3'd2, 2'd2, 9'd9,   9'd9,   2'd2, 1'b1, 1'b0, 1'b0, -1, 3'b001, 0, 1};
        vecs[6]  = '{2'd1, 2'd3, 3'd2, 2'd0, 9'd511, 9'd479, 2'd2, 1'b1, 1'b1, 1'b0,  0, 3'b001, 1, 0};
        vecs[7]  = '{2'd1, 2'd3, 3'd2, 2'd2, 9'd17,  9'd33,  2'd1, 1'b0, 1'b0, 1'b0,  1, 3'b011, 1, 0};
        vecs[8]  = '{2'd1, 2'd3, 3'd2, 2'd3, 9'd256, 9'd255, 2'd0, 1'b0, 1'b0, 1'b0,  2, 3'b111, 1, 0};
        vecs[9]  = '{2'd1, 2'd3, 3'd2, 2'd1, 9'd20,  9'd20,  2'd1, 1'b0, 1'b0, 1'b0, -1, 3'b111, 0, 1};
        vecs[10] = '{2'd1, 2'd3, 3'd0, 2'd3, 9'd1,   9'd2,   2'd1, 1'b1, 1'b1, 1'b0, -1, 3'b000, 1, 0};
        vecs[11] = '{2'd1, 2'd3, 3'd2, 2'd3, 9'd165, 9'd165, 2'd3, 1'b0, 1'b1, 1'b0,  2, 3'b100, 1, 0};

        rst_n           = 1'b0;
        rx_data         = 8'h00;
        rx_valid        = 1'b0;
        game_state      = 3'd2;
        num_players     = 2'd3;
        local_player_ID = 2'd0;
        idleCycles(3);
        checkOutput("reset.slot_valid", 32'(slot_valid), 32'd0);
        checkCounts("reset");
        for (int s = 0; s < 3; s++) checkSlot($sformatf("reset.slot%0d", s), s, 9'd0, 9'd0, 2'd3, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        idleCycles(2);

        // First packet as literal bytes: id1, x=144, y=200, dir down, chop.
        sendByte(8'hA5);
        sendByte(8'h2D);
        sendByte(8'h90);
        sendByte(8'hC8);
        sendByte(8'h75);
        exp_ok = 1;
        checkOutput("first.slot_valid", 32'(slot_valid), 32'b001);
        checkSlot("first.slot0", 0, 9'd144, 9'd200, 2'd3, 1'b1, 1'b0);
        checkCounts("first");

        for (int i = 0; i < 12; i++) begin
            local_player_ID = vecs[i].lid;
            num_players     = vecs[i].nump;
            game_state      = vecs[i].gs;
            idleCycles(2);
            applyStimulus(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].chop, vecs[i].carry,
                          vecs[i].bad);
            exp_ok  += vecs[i].ok_inc;
            exp_err += vecs[i].err_inc;
            checkCounts($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.slot_valid", i), 32'(slot_valid), 32'(vecs[i].exp_valid));
            for (int s = 0; s < 3; s++) begin
                if (s == vecs[i].exp_slot)
                    checkSlot($sformatf("vec%0d.slot%0d", i, s), s, vecs[i].x, vecs[i].y, vecs[i].dir,
                              vecs[i].chop, vecs[i].carry);
                else if (!vecs[i].exp_valid[s])
                    checkSlot($sformatf("vec%0d.parked%0d", i, s), s, 9'd0, 9'd0, 2'd3, 1'b0, 1'b0);
            end
        end

        // Idle in HUNT never aborts anything.
        idleCycles(2 * GAP);
        checkCounts("hunt_idle");

        // Stall after B1 for the full gap: abort, then a complete packet still lands.
        sendByte(8'hA5);
        sendByte(b1Of(2'd2, 9'd42, 9'd43, 2'd1, 1'b0, 1'b0));
        idleCycles(GAP);
        exp_err++;
        checkCounts("gap_abort");
        applyStimulus(2'd2, 9'd42, 9'd43, 2'd1, 1'b0, 1'b0, 1'b0);
        exp_ok++;
        checkCounts("gap_recover");
        checkSlot("gap_recover.slot1", 1, 9'd42, 9'd43, 2'd1, 1'b0, 1'b0);

        // A byte arriving exactly in the expiry cycle keeps the packet alive.
        sendByte(8'hA5);
        sendByte(b1Of(2'd0, 9'd60, 9'd61, 2'd2, 1'b1, 1'b0));
        idleCycles(GAP - 1);
        sendByte(8'd60);
        sendByte(8'd61);
        sendByte(b1Of(2'd0, 9'd60, 9'd61, 2'd2, 1'b1, 1'b0) ^ 8'd60 ^ 8'd61);
        exp_ok++;
        checkCounts("gap_edge");
        checkSlot("gap_edge.slot0", 0, 9'd60, 9'd61, 2'd2, 1'b1, 1'b0);

        // Slot b ages out exactly TMO cycles after its last commit.
        applyStimulus(2'd2, 9'd70, 9'd71, 2'd0, 1'b1, 1'b1, 1'b0);
        exp_ok++;
        idleCycles(TMO - 1);
        checkOutput("tmo_before.valid_b", 32'(slot_valid[1]), 32'd1);
        idleCycles(1);
        checkOutput("tmo_expired.valid_b", 32'(slot_valid[1]), 32'd0);
        checkSlot("tmo_expired.slot1", 1, 9'd0, 9'd0, 2'd3, 1'b0, 1'b0);

        // A commit landing on the expiry edge wins.
        applyStimulus(2'd2, 9'd77, 9'd78, 2'd1, 1'b0, 1'b0, 1'b0);
        idleCycles(TMO - 5);
        applyStimulus(2'd2, 9'd88, 9'd89, 2'd2, 1'b0, 1'b1, 1'b0);
        exp_ok += 2;
        checkOutput("tmo_race.valid_b", 32'(slot_valid[1]), 32'd1);
        checkSlot("tmo_race.slot1", 1, 9'd88, 9'd89, 2'd2, 1'b0, 1'b1);
        checkCounts("tmo_race");
        idleCycles(TMO - 1);
        checkOutput("tmo_restart.valid_b", 32'(slot_valid[1]), 32'd1);

        // Reset mid-packet, then the tail of the old packet must be ignored.
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h03);
        #1;
        rst_n = 1'b0;
        #2;
        exp_ok  = 0;
        exp_err = 0;
        checkOutput("midreset.slot_valid", 32'(slot_valid), 32'd0);
        checkCounts("midreset");
        checkSlot("midreset.slot0", 0, 9'd0, 9'd0, 2'd3, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        idleCycles(1);
        sendByte(8'h10);
        sendByte(8'h11);
        checkCounts("midreset_tail");
        checkOutput("midreset_tail.slot_valid", 32'(slot_valid), 32'd0);
        applyStimulus(2'd2, 9'd3, 9'd16, 2'd0, 1'b0, 1'b0, 1'b0);
        exp_ok = 1;
        checkOutput("post_reset.slot_valid", 32'(slot_valid), 32'b010);
        checkCounts("post_reset");

        for (int i = 0; i < 300; i++) applyStimulus(2'd1, 9'd5, 9'd5, 2'd0, 1'b0, 1'b0, 1'b0);
        exp_err = 255;
        checkCounts("err_saturate");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
